// File: rtl/add_share_arb_if.sv
// Bundle of request, shared-adder and response signals for add_share_arb.
// The slave modport is the arbiter side; master is the requester/adder/consumer side.
interface add_share_arb_if #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           add_start;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;
  logic           busy;

  modport slave (
    input  req_valid, req_a, req_b, add_y, rsp_ready,
    output req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_y, busy
  );

  modport master (
    output req_valid, req_a, req_b, add_y, rsp_ready,
    input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_id, rsp_y, busy
  );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one fixed-latency adder among N requesters,
// with a credit-limited in-order response FIFO.
module add_share_arb #(
  parameter int unsigned W     = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  add_share_arb_if.slave  bus
);
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned FW  = $clog2(LAT + DEPTH + 1);

  logic [IDW-1:0] rr_ptr;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];

  logic [W-1:0]   mem_y  [DEPTH];
  logic [IDW-1:0] mem_id [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic [FW-1:0]  used;
  logic           credit;
  logic           grant;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   ready;
  logic           push;
  logic           pop;
  logic           rsp_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits count registered state only, so a pop frees a slot one cycle later.
  always_comb begin
    used = '0;
    for (int unsigned s = 0; s < LAT; s++) used = used + FW'(tag_v[s]);
    used   = used + FW'(count);
    credit = (used < FW'(DEPTH));
  end

  always_comb begin
    logic [IDW:0]   sum_i;
    logic [IDW-1:0] idx;
    grant  = 1'b0;
    gnt_id = '0;
    ready  = '0;
    sum_i  = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_i = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum_i >= (IDW+1)'(N)) sum_i = sum_i - (IDW+1)'(N);
      idx = sum_i[IDW-1:0];
      if (!grant && credit && !rst && bus.req_valid[idx]) begin
        grant  = 1'b1;
        gnt_id = idx;
      end
    end
    if (grant) ready[gnt_id] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.add_start = grant;
  assign bus.add_a     = grant ? bus.req_a[gnt_id*W +: W] : '0;
  assign bus.add_b     = grant ? bus.req_b[gnt_id*W +: W] : '0;

  assign push      = tag_v[LAT-1];
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      rr_ptr <= '0;
    end else begin
      tag_v[0] <= grant;
      for (int unsigned s = 1; s < LAT; s++) tag_v[s] <= tag_v[s-1];
      if (grant) rr_ptr <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= gnt_id;
    for (int unsigned s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]  <= bus.add_y;
      mem_id[wr_ptr] <= tag_id[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields are forced to zero while empty so stale entries never show.
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_valid ? mem_id[rd_ptr] : '0;
  assign bus.rsp_y     = rsp_valid ? mem_y[rd_ptr]  : '0;
  assign bus.busy      = (|tag_v) | rsp_valid;
endmodule

// File: tb/tb_add_share_arb.sv
// Randomized bench for add_share_arb against a queue-based transaction model.
module tb_add_share_arb;
  localparam int unsigned W     = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    int unsigned  id;
    logic [W-1:0] y;
    int unsigned  due;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_share_arb_if #(.W(W), .N(N)) bus ();

  add_share_arb #(.W(W), .N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External adder: result of an issue appears on add_y LAT cycles later and holds.
  logic         pv [LAT-1];
  logic [W-1:0] ps [LAT-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT - 1; k++) pv[k] <= 1'b0;
      bus.add_y <= '0;
    end else begin
      pv[0] <= bus.add_start;
      ps[0] <= bus.add_a + bus.add_b;
      for (int k = 1; k < LAT - 1; k++) begin
        pv[k] <= pv[k-1];
        ps[k] <= ps[k-1];
      end
      if (pv[LAT-2]) bus.add_y <= ps[LAT-2];
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned rr_m     = 0;
  int          outstanding = 0;
  op_t pend [$];
  op_t fifo [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic rdy,
                      input logic fix, input logic [W-1:0] a0, input logic [W-1:0] b0);
    logic [W-1:0] av [N];
    logic [W-1:0] bv [N];
    logic [W-1:0] sum;
    int           g;
    op_t          o;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
    end
    if (fix) begin
      av[0] = a0;
      bv[0] = b0;
    end
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = av[i];
      bus.req_b[i*W +: W] = bv[i];
    end
    #1;
    while (pend.size() > 0 && pend[0].due <= cyc) fifo.push_back(pend.pop_front());

    g = -1;
    if (!r && (pend.size() + fifo.size() < DEPTH)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rr_m + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end

    check("req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("add_start", bus.add_start, (g >= 0) ? 1 : 0);
    check("add_a", bus.add_a, (g >= 0) ? av[g] : '0);
    check("add_b", bus.add_b, (g >= 0) ? bv[g] : '0);
    if (!r) begin
      check("rsp_valid", bus.rsp_valid, fifo.size() > 0);
      check("rsp_id", bus.rsp_id, (fifo.size() > 0) ? fifo[0].id : 0);
      check("rsp_y", bus.rsp_y, (fifo.size() > 0) ? fifo[0].y : '0);
      check("busy", bus.busy, (pend.size() + fifo.size()) > 0);
      // Ops granted by the DUT but not yet consumed must never exceed the FIFO size.
      if (bus.add_start) outstanding++;
      check("no_overflow", outstanding <= DEPTH, 1);
      if (bus.rsp_valid && rdy) outstanding--;
    end

    if (r) begin
      pend.delete();
      fifo.delete();
      rr_m        = 0;
      outstanding = 0;
    end else begin
      if (g >= 0) begin
        sum   = av[g] + bv[g];
        o.id  = g;
        o.y   = sum;
        o.due = cyc + LAT + 1;
        pend.push_back(o);
        rr_m = (g + 1) % N;
      end
      if (fifo.size() > 0 && rdy) void'(fifo.pop_front());
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, '0, '0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0, '0, '0);
    idle(2, 1'b1);

    // single op and carry wrap
    step(1'b0, 4'b0001, 1'b1, 1'b1, 16'd3, 16'd4);
    idle(5, 1'b1);
    step(1'b0, 4'b0001, 1'b1, 1'b1, 16'hFFFF, 16'h0002);
    idle(5, 1'b1);

    // round robin with everyone requesting
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b1, 1'b0, '0, '0);
    idle(5, 1'b1);

    // backpressure, then release
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b1, 1'b0, '0, '0);
    idle(6, 1'b1);

    // push and pop on the same edge with two entries buffered
    step(1'b0, 4'b0001, 1'b0, 1'b0, '0, '0);
    step(1'b0, 4'b0010, 1'b0, 1'b0, '0, '0);
    step(1'b0, 4'b0100, 1'b0, 1'b0, '0, '0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // reset while ops are in flight
    step(1'b0, 4'b0100, 1'b1, 1'b0, '0, '0);
    step(1'b0, 4'b1000, 1'b1, 1'b0, '0, '0);
    step(1'b1, 4'b1111, 1'b1, 1'b0, '0, '0);
    idle(6, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 1'b0, '0, '0);
    idle(5, 1'b1);

    for (int seg = 0; seg < 20; seg++) begin
      int unsigned dens, rprob;
      dens  = $urandom_range(5, 95);
      rprob = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        logic [N-1:0] v;
        logic         r;
        for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 99) < dens);
        r = ($urandom_range(0, 299) == 0);
        step(r, v, $urandom_range(0, 99) < rprob, 1'b0, '0, '0);
      end
    end
    idle(10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/add_share_arb.md
ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W  16  operand/result width
  N  4  number of requesters (N >= 2)
  LAT  2  adder latency, add_start cycle to result-visible cycle
  DEPTH  4  response FIFO entries (DEPTH >= LAT)
REQ-002 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high. Ports, one per line: name, direction, width, meaning (clock and reset first).
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  N  per-requester operation request
  req_a  in  N*W  operand A; requester i at bits [i*W +: W]
  req_b  in  N*W  operand B, same packing
  req_ready  out  N  one-hot grant; transfer when req_valid[i] & req_ready[i]
  add_start  out  1  issue strobe to shared adder
  add_a  out  W  operand A to adder
  add_b  out  W  operand B to adder
  add_y  in  W  adder result; holds between issues
  rsp_valid  out  1  response available
  rsp_ready  in  1  consumer accepts response
  rsp_id  out  clog2(N)  requester index of response
  rsp_y  out  W  sum (a+b) mod 2^W
  busy  out  1  any op in flight or buffered

Function
REQ-003 Issue SHALL be allowed in a cycle only if (in-flight count + FIFO occupancy) < DEPTH, both taken from registered state; a pop in the same cycle SHALL NOT free a credit until the next cycle.
REQ-004 When issue is allowed and any req_valid is high, exactly one req_ready bit SHALL assert: the first requester with req_valid high searching upward from rr_ptr, wrapping N-1 -> 0; otherwise req_ready SHALL be all zero.
REQ-005 req_ready SHALL be combinational from req_valid, rr_ptr and credit state; no req_ready bit SHALL assert for a requester with req_valid low.
REQ-006 On a grant to i: add_start = 1, add_a/add_b = requester i operands in the same cycle; otherwise add_start = 0, add_a = add_b = 0.
REQ-007 On a grant to i, rr_ptr SHALL update to (i+1) mod N; without a grant rr_ptr SHALL hold.
REQ-008 Maximum throughput SHALL be one issue per cycle; back-to-back grants SHALL be legal.
REQ-009 A LAT-stage tag pipeline of {valid, id} SHALL track each issue; an op issued in cycle t SHALL exit at cycle t+LAT, when add_y SHALL be written with its id into the FIFO.
REQ-010 The FIFO SHALL be DEPTH entries, first-in first-out, with read/write pointers wrapping modulo DEPTH; rsp_valid = FIFO not empty; rsp_id/rsp_y = head entry.
REQ-011 Pop SHALL occur on rsp_valid & rsp_ready; push and pop in the same cycle SHALL both take effect with occupancy unchanged.
REQ-012 By REQ-003 a push into a full FIFO SHALL never occur; the verification bench SHALL flag it as an error.
REQ-013 Response latency SHALL be LAT+1 cycles minimum (issue in cycle t -> rsp_valid in cycle t+LAT+1); responses SHALL return in issue order.
REQ-014 busy SHALL be high iff any tag stage is valid or the FIFO is non-empty.
REQ-015 rsp_y SHALL be the W-bit sum with carry discarded.

Reset
REQ-016 While rst is high at a rising clk edge: rr_ptr = 0, tag pipeline cleared, FIFO pointers and occupancy = 0; in-flight and buffered ops SHALL be discarded without response.
REQ-017 During and after reset: req_ready = 0, add_start = 0, add_a = add_b = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, busy = 0 until the first post-reset grant.
REQ-018 Assertion of rst mid-operation SHALL take effect at that edge regardless of pending handshakes.

Verification
REQ-019 Single op: req_valid = 0001, a0 = 3, b0 = 4 in cycle t -> req_ready = 0001, add_start = 1 in t; rsp_valid, rsp_id = 0, rsp_y = 7 in cycle t+3.
REQ-020 Round-robin: all four requesters valid continuously, rsp_ready = 1 -> grants in order 0, 1, 2, 3, 0 on consecutive cycles; responses in the same id order.
REQ-021 Wrap: a = 16'hFFFF, b = 16'h0002 -> rsp_y = 16'h0001.
REQ-022 Backpressure: rsp_ready = 0, all requesters valid -> exactly 4 grants, then req_ready = 0; FIFO fills to 4; rsp_ready = 1 -> 4 in-order responses, one-cycle credit lag before the next grant.
REQ-023 Simultaneous push/pop: FIFO at 2 entries, push and pop in the same cycle -> occupancy stays 2, head advances.
REQ-024 Reset mid-flight: 2 ops issued, rst = 1 one cycle later -> no responses ever appear; busy = 0 and rr_ptr = 0 after reset.
